// File: rtl/branch_control_unit.sv
// Branch control unit: decodes JMP/BEQ/BNE/HALT from the fetched instruction,
// compares register operands and drives the program counter's control inputs.
// Wrong-path instructions are squashed after every taken transfer or roll-over.
module branch_control_unit #(
   parameter logic [15:0] END_ADDR      = 16'h0FFE,
   parameter int          SQUASH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   input  logic [15:0] pc_addr,
   input  logic [15:0] rs_data,
   input  logic [15:0] rt_data,
   output logic [2:0]  rs_addr,
   output logic [2:0]  rt_addr,
   output logic [1:0]  jump_control,
   output logic [14:0] load_data,
   output logic        eq_flag,
   output logic        roll_over,
   output logic        halted,
   output logic [15:0] taken_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_SQUASH = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_BEQ  = 4'b1101;
   localparam logic [3:0] OP_BNE  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] JC_NEXT = 2'b00;
   localparam logic [1:0] JC_JUMP = 2'b01;
   localparam logic [1:0] JC_BEQ  = 2'b10;
   localparam logic [1:0] JC_BNE  = 2'b11;

   // Squash counter starts one below the cycle count so "reads 0" marks the last ignored cycle.
   localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES - 1);

   state_t       state_reg, state_next;
   logic [2:0]   squash_cnt_reg, squash_cnt_next;
   logic [1:0]   jump_control_reg, jump_control_next;
   logic [14:0]  load_data_reg, load_data_next;
   logic         eq_flag_reg, eq_flag_next;
   logic         roll_over_reg, roll_over_next;
   logic [15:0]  taken_count_reg, taken_count_next;
   logic         taken_inc;

   // Instruction decode and operand compare.
   logic [3:0]   opcode;
   logic         is_jmp, is_beq, is_bne, is_halt;
   logic         operands_eq, branch_taken, end_of_prog;
   logic [14:0]  branch_offset;

   assign opcode        = instr[15:12];
   assign is_jmp        = instr_valid && (opcode == OP_JMP);
   assign is_beq        = instr_valid && (opcode == OP_BEQ);
   assign is_bne        = instr_valid && (opcode == OP_BNE);
   assign is_halt       = instr_valid && (opcode == OP_HALT);
   assign operands_eq   = (rs_data == rt_data);
   assign branch_taken  = (is_beq && operands_eq) || (is_bne && !operands_eq);
   // pc_addr is compared as an unsigned quantity, so "negative" addresses also roll over.
   assign end_of_prog   = (pc_addr >= END_ADDR);
   assign branch_offset = {{9{instr[5]}}, instr[5:0]};

   assign rs_addr = instr[11:9];
   assign rt_addr = instr[8:6];

   // State and output registers; async reset pins the PC at 0 via roll_over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         squash_cnt_reg   <= 3'd0;
         jump_control_reg <= JC_NEXT;
         load_data_reg    <= 15'd0;
         eq_flag_reg      <= 1'b0;
         roll_over_reg    <= 1'b1;
         taken_count_reg  <= 16'd0;
      end else begin
         state_reg        <= state_next;
         squash_cnt_reg   <= squash_cnt_next;
         jump_control_reg <= jump_control_next;
         load_data_reg    <= load_data_next;
         eq_flag_reg      <= eq_flag_next;
         roll_over_reg    <= roll_over_next;
         taken_count_reg  <= taken_count_next;
      end
   end

   // Next-state and squash counter selection.
   always_comb begin
      state_next      = state_reg;
      squash_cnt_next = squash_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            if (end_of_prog || is_jmp || branch_taken) begin
               state_next      = S_SQUASH;
               squash_cnt_next = SQUASH_LOAD;
            end else if (is_halt) begin
               state_next = S_HALT;
            end
         end
         S_SQUASH: begin
            if (squash_cnt_reg == 3'd0) state_next = S_RUN;
            else                        squash_cnt_next = squash_cnt_reg - 3'd1;
         end
         S_HALT: begin
            if (start) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Next values for the registered PC-control outputs.
   always_comb begin
      jump_control_next = JC_NEXT;
      load_data_next    = load_data_reg;
      eq_flag_next      = 1'b0;
      roll_over_next    = 1'b0;
      taken_inc         = 1'b0;
      case (state_reg)
         S_IDLE: begin
            roll_over_next = !start;
         end
         S_RUN: begin
            if (end_of_prog) begin
               // Roll-over outranks any transfer in the same cycle; the transfer is dropped.
               roll_over_next = 1'b1;
            end else if (is_jmp) begin
               jump_control_next = JC_JUMP;
               load_data_next    = {3'b000, instr[11:0]};
               taken_inc         = 1'b1;
            end else if (is_beq || is_bne) begin
               jump_control_next = is_beq ? JC_BEQ : JC_BNE;
               load_data_next    = branch_offset;
               eq_flag_next      = operands_eq;
               taken_inc         = branch_taken;
            end else if (is_halt) begin
               // Jump target is a word address, so the PC keeps re-fetching the HALT.
               jump_control_next = JC_JUMP;
               load_data_next    = {3'b000, pc_addr[12:1]};
            end
         end
         S_SQUASH: begin
            jump_control_next = JC_NEXT;
         end
         S_HALT: begin
            if (start) roll_over_next = 1'b1;
            else       jump_control_next = JC_JUMP;
         end
         default: roll_over_next = 1'b1;
      endcase
   end

   // Saturating counter of taken JMP/BEQ/BNE transfers.
   always_comb begin
      taken_count_next = taken_count_reg;
      if (taken_inc && (taken_count_reg != 16'hFFFF))
         taken_count_next = taken_count_reg + 16'd1;
   end

   assign jump_control = jump_control_reg;
   assign load_data    = load_data_reg;
   assign eq_flag      = eq_flag_reg;
   assign roll_over    = roll_over_reg;
   assign taken_count  = taken_count_reg;
   assign halted       = (state_reg == S_HALT);

endmodule
